// File: rtl/hash_table_pkg.sv
// Shared hash-table result types: command/result-code enums and the packed result word.
package hash_table;

    localparam int unsigned KEY_WIDTH    = 32;
    localparam int unsigned VALUE_WIDTH  = 16;
    localparam int unsigned NUM_RESCODES = 7;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        INSERT = 2'd1,
        DELETE = 2'd2,
        NOP    = 2'd3
    } ht_cmd_t;

    // Encoding 3'd7 is unused; it reaches only the total counter.
    typedef enum logic [2:0] {
        SEARCH_FOUND                     = 3'd0,
        SEARCH_NOT_FOUND                 = 3'd1,
        INSERT_SUCCESS                   = 3'd2,
        INSERT_SUCCESS_SAME_KEY          = 3'd3,
        INSERT_NOT_SUCCESS_TABLE_IS_FULL = 3'd4,
        DELETE_SUCCESS                   = 3'd5,
        DELETE_NOT_SUCCESS_NO_ENTRY      = 3'd6
    } ht_rescode_t;

    typedef struct packed {
        ht_cmd_t                 cmd;
        logic [KEY_WIDTH-1:0]    key;
        logic [VALUE_WIDTH-1:0]  value;
        ht_rescode_t             rescode;
    } ht_result_t;

endpackage

// File: rtl/ht_res_if.sv
// Hash-table result stream: valid/ready handshake carrying one result per beat.
interface ht_res_if;
    import hash_table::*;

    logic                    valid;
    logic                    ready;
    ht_cmd_t                 cmd;
    logic [KEY_WIDTH-1:0]    key;
    logic [VALUE_WIDTH-1:0]  value;
    ht_rescode_t             rescode;

    modport consumer (input valid, cmd, key, value, rescode, output ready);
    modport producer (output valid, cmd, key, value, rescode, input ready);
endinterface

// File: rtl/ht_res_fifo.sv
// First-word-fall-through result FIFO; head entry is read combinationally from storage.
module ht_res_fifo
    import hash_table::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  ht_result_t             wr_data,
    input  logic                   rd_en,
    output ht_result_t             rd_data,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    ht_result_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && (level != LVL_W'(DEPTH));
    assign do_rd   = rd_en && (level != '0);
    assign rd_data = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_wr, do_rd})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ht_res_collector.sv
// Buffers hash-table results for host readout and keeps saturating per-result-code statistics.
module ht_res_collector
    import hash_table::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    ht_res_if.consumer              ht_res_in,
    input  logic                    rd_req_i,
    output logic                    rd_valid_o,
    output ht_cmd_t                 rd_cmd_o,
    output logic [KEY_WIDTH-1:0]    rd_key_o,
    output logic [VALUE_WIDTH-1:0]  rd_value_o,
    output ht_rescode_t             rd_rescode_o,
    output logic [$clog2(DEPTH):0]  level_o,
    input  logic                    clr_stats_i,
    output logic [CNT_WIDTH-1:0]    cnt_o [NUM_RESCODES],
    output logic [CNT_WIDTH-1:0]    cnt_total_o
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic       ready;
    logic       push;
    logic       pop;
    ht_result_t wr_word;
    ht_result_t head;

    assign ready           = !rst_i && (level_o < LVL_W'(DEPTH));
    assign ht_res_in.ready = ready;
    assign push            = ht_res_in.valid && ready;
    assign rd_valid_o      = (level_o != '0);
    assign pop             = rd_req_i && rd_valid_o;

    assign wr_word = '{cmd: ht_res_in.cmd, key: ht_res_in.key,
                       value: ht_res_in.value, rescode: ht_res_in.rescode};

    ht_res_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_en   (push),
        .wr_data (wr_word),
        .rd_en   (pop),
        .rd_data (head),
        .level   (level_o)
    );

    assign rd_cmd_o     = head.cmd;
    assign rd_key_o     = head.key;
    assign rd_value_o   = head.value;
    assign rd_rescode_o = head.rescode;

    // Clear wins over history but still counts an accept in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_RESCODES; i++) cnt_o[i] <= '0;
            cnt_total_o <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_RESCODES; i++) begin
                if (clr_stats_i)
                    cnt_o[i] <= (push && 32'(ht_res_in.rescode) == i) ? CNT_WIDTH'(1) : '0;
                else if (push && 32'(ht_res_in.rescode) == i && cnt_o[i] != CNT_MAX)
                    cnt_o[i] <= cnt_o[i] + CNT_WIDTH'(1);
            end
            if (clr_stats_i)
                cnt_total_o <= push ? CNT_WIDTH'(1) : '0;
            else if (push && cnt_total_o != CNT_MAX)
                cnt_total_o <= cnt_total_o + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_ht_res_collector.sv
// Bench for ht_res_collector: fixed vector table, directed corner sequences and a randomized run.
module tb_ht_res_collector;
    import hash_table::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW_A  = 32;
    localparam int unsigned CW_B  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid, rd_req, clr;
    ht_cmd_t     cmd;
    logic [31:0] key;
    logic [15:0] value;
    ht_rescode_t rescode;

    ht_res_if bus_a ();
    ht_res_if bus_b ();
    assign bus_a.valid = valid;   assign bus_b.valid = valid;
    assign bus_a.cmd = cmd;       assign bus_b.cmd = cmd;
    assign bus_a.key = key;       assign bus_b.key = key;
    assign bus_a.value = value;   assign bus_b.value = value;
    assign bus_a.rescode = rescode; assign bus_b.rescode = rescode;

    logic            rd_valid_a, rd_valid_b;
    ht_cmd_t         rd_cmd_a, rd_cmd_b;
    logic [31:0]     rd_key_a, rd_key_b;
    logic [15:0]     rd_value_a, rd_value_b;
    ht_rescode_t     rd_rc_a, rd_rc_b;
    logic [4:0]      level_a, level_b;
    logic [CW_A-1:0] cnt_a [NUM_RESCODES];
    logic [CW_B-1:0] cnt_b [NUM_RESCODES];
    logic [CW_A-1:0] total_a;
    logic [CW_B-1:0] total_b;

    ht_res_collector #(.DEPTH(DEPTH), .CNT_WIDTH(CW_A)) dut_a (
        .clk_i(clk), .rst_i(rst), .ht_res_in(bus_a), .rd_req_i(rd_req),
        .rd_valid_o(rd_valid_a), .rd_cmd_o(rd_cmd_a), .rd_key_o(rd_key_a),
        .rd_value_o(rd_value_a), .rd_rescode_o(rd_rc_a), .level_o(level_a),
        .clr_stats_i(clr), .cnt_o(cnt_a), .cnt_total_o(total_a));

    ht_res_collector #(.DEPTH(DEPTH), .CNT_WIDTH(CW_B)) dut_b (
        .clk_i(clk), .rst_i(rst), .ht_res_in(bus_b), .rd_req_i(rd_req),
        .rd_valid_o(rd_valid_b), .rd_cmd_o(rd_cmd_b), .rd_key_o(rd_key_b),
        .rd_value_o(rd_value_b), .rd_rescode_o(rd_rc_b), .level_o(level_b),
        .clr_stats_i(clr), .cnt_o(cnt_b), .cnt_total_o(total_b));

    int vectors = 0;
    int miscompares = 0;

    // Reference: unbounded queue plus true event counts; saturation is min(count, max).
    ht_result_t      mq [$];
    longint unsigned mcnt [NUM_RESCODES];
    longint unsigned mtotal;

    function automatic longint unsigned sat(longint unsigned v, int w);
        longint unsigned mx = (64'd1 << w) - 64'd1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        bit push, pop;
        push = !rst && valid && (mq.size() < DEPTH);
        pop  = !rst && rd_req && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            foreach (mcnt[i]) mcnt[i] = 0;
            mtotal = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back('{cmd: cmd, key: key, value: value, rescode: rescode});
            if (clr) begin
                foreach (mcnt[i]) mcnt[i] = 0;
                mtotal = 0;
            end
            if (push) begin
                mtotal++;
                if (int'(rescode) < NUM_RESCODES) mcnt[int'(rescode)]++;
            end
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, ".level"}, 64'(level_a), 64'(mq.size()));
        chk({tag, ".level_b"}, 64'(level_b), 64'(mq.size()));
        chk({tag, ".rd_valid"}, 64'(rd_valid_a), 64'(mq.size() > 0));
        chk({tag, ".ready"}, 64'(bus_a.ready), 64'(!rst && mq.size() < DEPTH));
        if (mq.size() > 0) begin
            chk({tag, ".key"}, 64'(rd_key_a), 64'(mq[0].key));
            chk({tag, ".value"}, 64'(rd_value_a), 64'(mq[0].value));
            chk({tag, ".cmd"}, 64'(rd_cmd_a), 64'(mq[0].cmd));
            chk({tag, ".rescode"}, 64'(rd_rc_a), 64'(mq[0].rescode));
        end
        for (int i = 0; i < NUM_RESCODES; i++) begin
            chk($sformatf("%s.cnt_a[%0d]", tag, i), 64'(cnt_a[i]), sat(mcnt[i], CW_A));
            chk($sformatf("%s.cnt_b[%0d]", tag, i), 64'(cnt_b[i]), sat(mcnt[i], CW_B));
        end
        chk({tag, ".total_a"}, 64'(total_a), sat(mtotal, CW_A));
        chk({tag, ".total_b"}, 64'(total_b), sat(mtotal, CW_B));
    endtask

    task automatic idle();
        valid = 0; rd_req = 0; clr = 0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); rst = 0;
    endtask

    task automatic push_one(logic [31:0] k, ht_rescode_t rc);
        valid = 1; cmd = INSERT; key = k; value = k[15:0]; rescode = rc;
        tick();
        valid = 0;
    endtask

    typedef struct {
        logic        rst, valid, rd_req, clr;
        ht_cmd_t     cmd;
        logic [2:0]  rc;
        logic [31:0] key;
        logic [15:0] value;
        int          e_level;
        logic        e_valid, e_ready;
        logic [31:0] e_key;
        logic [15:0] e_value;
        int          e_total, e_sf, e_is;
    } vec_t;

    vec_t tbl [9];

    initial begin
        rst = 1; idle(); cmd = SEARCH; key = '0; value = '0; rescode = SEARCH_FOUND;
        foreach (mcnt[i]) mcnt[i] = 0;
        mtotal = 0;

        //          rst v  rq clr cmd     rc    key           value     lvl vld rdy e_key         e_val    tot sf is
        tbl[0] = '{1'b1,1'b0,1'b0,1'b0, SEARCH, 3'd0, 32'h0,        16'h0,    0, 1'b0,1'b0, 32'h0,        16'h0,    0, 0, 0};
        tbl[1] = '{1'b0,1'b0,1'b0,1'b0, SEARCH, 3'd0, 32'h0,        16'h0,    0, 1'b0,1'b1, 32'h0,        16'h0,    0, 0, 0};
        tbl[2] = '{1'b0,1'b1,1'b0,1'b0, SEARCH, 3'd0, 32'h01000000, 16'h1234, 1, 1'b1,1'b1, 32'h01000000, 16'h1234, 1, 1, 0};
        tbl[3] = '{1'b0,1'b1,1'b1,1'b0, INSERT, 3'd2, 32'h2,        16'h2,    1, 1'b1,1'b1, 32'h2,        16'h2,    2, 1, 1};
        tbl[4] = '{1'b0,1'b0,1'b1,1'b0, SEARCH, 3'd0, 32'h0,        16'h0,    0, 1'b0,1'b1, 32'h0,        16'h0,    2, 1, 1};
        tbl[5] = '{1'b0,1'b0,1'b1,1'b0, SEARCH, 3'd0, 32'h0,        16'h0,    0, 1'b0,1'b1, 32'h0,        16'h0,    2, 1, 1};
        tbl[6] = '{1'b0,1'b1,1'b0,1'b1, INSERT, 3'd2, 32'h3,        16'h3,    1, 1'b1,1'b1, 32'h3,        16'h3,    1, 0, 1};
        tbl[7] = '{1'b0,1'b0,1'b0,1'b1, SEARCH, 3'd0, 32'h0,        16'h0,    1, 1'b1,1'b1, 32'h3,        16'h3,    0, 0, 0};
        tbl[8] = '{1'b0,1'b1,1'b0,1'b0, DELETE, 3'd7, 32'h4,        16'h4,    2, 1'b1,1'b1, 32'h3,        16'h3,    1, 0, 0};

        for (int i = 0; i < 9; i++) begin
            rst = tbl[i].rst; valid = tbl[i].valid; rd_req = tbl[i].rd_req; clr = tbl[i].clr;
            cmd = tbl[i].cmd; rescode = ht_rescode_t'(tbl[i].rc);
            key = tbl[i].key; value = tbl[i].value;
            tick();
            chk($sformatf("tbl%0d.level", i), 64'(level_a), 64'(tbl[i].e_level));
            chk($sformatf("tbl%0d.rd_valid", i), 64'(rd_valid_a), 64'(tbl[i].e_valid));
            chk($sformatf("tbl%0d.ready", i), 64'(bus_a.ready), 64'(tbl[i].e_ready));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d.key", i), 64'(rd_key_a), 64'(tbl[i].e_key));
                chk($sformatf("tbl%0d.value", i), 64'(rd_value_a), 64'(tbl[i].e_value));
            end
            chk($sformatf("tbl%0d.total", i), 64'(total_a), 64'(tbl[i].e_total));
            chk($sformatf("tbl%0d.cnt_sf", i), 64'(cnt_a[SEARCH_FOUND]), 64'(tbl[i].e_sf));
            chk($sformatf("tbl%0d.cnt_is", i), 64'(cnt_b[INSERT_SUCCESS]), 64'(tbl[i].e_is));
            if (i == 2) begin
                chk("tbl2.cmd", 64'(rd_cmd_a), 64'(SEARCH));
                chk("tbl2.rescode", 64'(rd_rc_a), 64'(SEARCH_FOUND));
            end
        end

        // Fill to full, offer one more, then drain in order.
        do_reset();
        for (int i = 0; i < 16; i++) push_one(32'(100 + i), SEARCH_NOT_FOUND);
        chk("full.level", 64'(level_a), 64'd16);
        chk("full.ready", 64'(bus_a.ready), 64'd0);
        valid = 1; key = 32'd999; tick(); valid = 0;
        chk("full.17th_level", 64'(level_a), 64'd16);
        chk("full.17th_total", 64'(total_a), 64'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d.key", i), 64'(rd_key_a), 64'(100 + i));
            rd_req = 1; tick();
        end
        rd_req = 0;
        chk("drain.rd_valid", 64'(rd_valid_a), 64'd0);
        chk("drain.level", 64'(level_a), 64'd0);

        // Steady push+pop at level 5 across several pointer wraps.
        do_reset();
        for (int i = 0; i < 5; i++) push_one(32'(200 + i), DELETE_SUCCESS);
        for (int c = 0; c < 40; c++) begin
            valid = 1; rd_req = 1; key = 32'(205 + c); value = 16'(c);
            tick();
            chk($sformatf("wrap%0d.level", c), 64'(level_a), 64'd5);
            chk($sformatf("wrap%0d.key", c), 64'(rd_key_a), 64'(201 + c));
        end
        idle();
        check_model("wrap.end");

        // Saturation of the narrow counters.
        do_reset();
        valid = 1; rd_req = 1; rescode = INSERT_SUCCESS_SAME_KEY;
        for (int c = 0; c < 20; c++) begin key = 32'(c); tick(); end
        idle();
        chk("sat.total_b", 64'(total_b), 64'd15);
        chk("sat.cnt_b", 64'(cnt_b[INSERT_SUCCESS_SAME_KEY]), 64'd15);
        chk("sat.total_a", 64'(total_a), 64'd20);

        // Clear coinciding with an INSERT_SUCCESS accept.
        push_one(32'h55, SEARCH_FOUND);
        push_one(32'h56, DELETE_NOT_SUCCESS_NO_ENTRY);
        clr = 1; valid = 1; rescode = INSERT_SUCCESS; key = 32'h57; tick(); idle();
        for (int i = 0; i < NUM_RESCODES; i++)
            chk($sformatf("clr.cnt[%0d]", i), 64'(cnt_a[i]), (i == int'(INSERT_SUCCESS)) ? 64'd1 : 64'd0);
        chk("clr.total", 64'(total_a), 64'd1);
        chk("clr.level_kept", 64'(level_a), 64'(mq.size()));

        // Reset in the middle of a stream.
        do_reset();
        for (int i = 0; i < 7; i++) push_one(32'(300 + i), SEARCH_FOUND);
        chk("rst.level_before", 64'(level_a), 64'd7);
        rst = 1; tick();
        chk("rst.level", 64'(level_a), 64'd0);
        chk("rst.rd_valid", 64'(rd_valid_a), 64'd0);
        chk("rst.ready", 64'(bus_a.ready), 64'd0);
        chk("rst.total", 64'(total_a), 64'd0);
        chk("rst.cnt_sf", 64'(cnt_a[SEARCH_FOUND]), 64'd0);
        rst = 0; #1;
        chk("rst.ready_after", 64'(bus_a.ready), 64'd1);

        // Randomized traffic with drifting fill/drain bias.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int unsigned rd_pct;
            rd_pct = ((c / 250) % 2 == 0) ? 25 : 75;
            rst     = ($urandom_range(999) == 0);
            valid   = ($urandom_range(99) < 70);
            rd_req  = ($urandom_range(99) < rd_pct);
            clr     = ($urandom_range(63) == 0);
            cmd     = ht_cmd_t'(2'($urandom));
            rescode = ht_rescode_t'(3'($urandom));
            key     = $urandom;
            value   = 16'($urandom);
            tick();
            check_model($sformatf("rnd%0d", c));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ht_res_collector.md
HT_RES_COLLECTOR -- requirements
Module: ht_res_collector

Interface
REQ-001 Parameter DEPTH, default 16, result FIFO depth; power of two, minimum 2.
REQ-002 Parameter CNT_WIDTH, default 32, width of each statistics counter.
REQ-003 clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 ht_res_in  ht_res_if (consumer side)  --  hash-table result stream; fields valid, ready, cmd, key, value, rescode; this block drives ready.
REQ-006 rd_req_i  input  1  host pop request for the FIFO head.
REQ-007 rd_valid_o  output  1  FIFO head holds a valid result.
REQ-008 rd_cmd_o / rd_key_o / rd_value_o / rd_rescode_o  output  ht_cmd_t / KEY_WIDTH / VALUE_WIDTH / ht_rescode_t  FIFO head fields.
REQ-009 level_o  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-010 clr_stats_i  input  1  synchronous clear of all statistics counters.
REQ-011 cnt_o[rescode]  output  NUM_RESCODES x CNT_WIDTH  one event counter per ht_rescode_t value.
REQ-012 cnt_total_o  output  CNT_WIDTH  total accepted results.

Function
REQ-013 A result is accepted in a cycle when ht_res_in.valid and ht_res_in.ready are both 1.
REQ-014 ht_res_in.ready is 1 exactly when level_o < DEPTH; it is registered-free (combinational from occupancy) and never depends on ht_res_in.valid.
REQ-015 An accepted result is written to the FIFO tail and is visible on rd_*_o no earlier than the next cycle (first-word-fall-through, 1-cycle latency).
REQ-016 rd_valid_o is 1 exactly when level_o > 0; rd_*_o present the oldest entry while rd_valid_o is 1.
REQ-017 A pop occurs when rd_req_i and rd_valid_o are both 1; rd_req_i with rd_valid_o = 0 is ignored with no state change.
REQ-018 Simultaneous accept and pop: level_o unchanged, both occur; when empty only the accept occurs; when full, no accept occurs because ready = 0.
REQ-019 Read/write pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-020 Results leave the FIFO in acceptance order.
REQ-021 On each accept, cnt_o[rescode] and cnt_total_o each increment by 1; rescode values outside the enum update cnt_total_o only.
REQ-022 Counters saturate at 2^CNT_WIDTH-1 and do not wrap.
REQ-023 clr_stats_i = 1 with no accept: all counters go to 0 next cycle.
REQ-024 clr_stats_i = 1 with an accept in the same cycle: counters go to 0, except the matching cnt_o[rescode] and cnt_total_o, which go to 1.
REQ-025 clr_stats_i does not affect FIFO contents or pointers.

Reset
REQ-026 While rst_i = 1: pointers and level_o = 0, ht_res_in.ready = 0, rd_valid_o = 0, and all counters = 0.
REQ-027 rd_cmd_o, rd_key_o, rd_value_o and rd_rescode_o are don't-care while rd_valid_o = 0; FIFO storage is not reset.
REQ-028 Reset asserted mid-stream discards all buffered results; ready rises in the first cycle after rst_i falls.

Structure
REQ-029 ht_rescode_t, NUM_RESCODES, KEY_WIDTH, VALUE_WIDTH and ht_cmd_t reside in package hash_table.
REQ-030 The FIFO is sub-module ht_res_fifo (FWFT, packed result word, DEPTH parameter); counters and ready logic sit in ht_res_collector.

Verification
REQ-031 After reset, push 1 result (SEARCH, key 32'h01000000, value 16'h1234, SEARCH_FOUND) -> next cycle rd_valid_o = 1 with those fields, cnt_o[SEARCH_FOUND] = 1, cnt_total_o = 1.
REQ-032 Push 16 results with rd_req_i = 0 -> level_o = 16, ready = 0; offered 17th not accepted; 16 pops return keys in order, rd_valid_o = 0 after the last.
REQ-033 With level_o = 5, hold valid and rd_req_i for 40 cycles -> level_o stays 5, pointers wrap, data order preserved.
REQ-034 Preload cnt_total_o to 2^CNT_WIDTH-1 by forcing CNT_WIDTH = 4 and pushing 20 results -> counter holds 15.
REQ-035 Assert clr_stats_i in the same cycle as an INSERT_SUCCESS accept -> cnt_o[INSERT_SUCCESS] = 1, cnt_total_o = 1, all other counters = 0.
REQ-036 Assert rst_i with level_o = 7 -> level_o = 0, rd_valid_o = 0, counters = 0; ready = 1 in the first cycle after rst_i deasserts.
